// File: rtl/frog_game_ctrl.sv
// Frogger playfield game-state controller: frog position, lane obstacles, hazards, lives and game FSM.
// Latency: every output is registered; moves, obstacle steps and start take effect on the sampling edge.
// Backpressure: none; move/tick/start are one-cycle pulses, each is either honoured or dropped that cycle.
module frog_game_ctrl #(
    parameter int STEP_TICKS  = 8,
    parameter int LIVES       = 3,
    parameter int DEATH_TICKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        tick,
    output logic [3:0]  frog_x,
    output logic [3:0]  frog_y,
    output logic [15:0] car_x,
    output logic [11:0] log_x,
    output logic [1:0]  lives,
    output logic [2:0]  state,
    output logic        frog_visible
);

    localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    // At least 3 bits so the blink bit (counter[2]) always exists.
    localparam int DW = (DEATH_TICKS > 8) ? $clog2(DEATH_TICKS) : 3;
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_TICKS - 1);
    localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DEATH = 3'd2,
        S_WIN   = 3'd3,
        S_OVER  = 3'd4
    } game_state_t;

    game_state_t   state_q, state_n;
    logic [3:0]    fx_q, fx_n, fy_q, fy_n;
    logic [3:0]    car_q [4];
    logic [3:0]    car_n [4];
    logic [3:0]    log_q [3];
    logic [3:0]    log_n [3];
    logic [1:0]    lives_q, lives_n;
    logic          vis_q, vis_n;
    logic [SW-1:0] step_q, step_n;
    logic [DW-1:0] dcnt_q, dcnt_n, dcnt_inc;

    logic [3:0]    mx, my;
    logic [3:0]    lane_car, lane_log, log_off;
    logic          on_road, on_river, car_hit, log_miss;

    // Column arithmetic on the 11-wide playfield.
    function automatic logic [3:0] inc11(input logic [3:0] v);
        return (v == 4'd10) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] dec11(input logic [3:0] v);
        return (v == 4'd0) ? 4'd10 : v - 4'd1;
    endfunction

    assign frog_x       = fx_q;
    assign frog_y       = fy_q;
    assign car_x        = {car_q[3], car_q[2], car_q[1], car_q[0]};
    assign log_x        = {log_q[2], log_q[1], log_q[0]};
    assign lives        = lives_q;
    assign state        = state_q;
    assign frog_visible = vis_q;
    assign dcnt_inc     = dcnt_q + 1'b1;

    // Hazard detection on the registered frog position and obstacle lanes.
    always_comb begin
        on_road  = (fy_q >= 4'd3) && (fy_q <= 4'd6);
        on_river = (fy_q >= 4'd7) && (fy_q <= 4'd9);
        unique case (fy_q)
            4'd4:    lane_car = car_q[1];
            4'd5:    lane_car = car_q[2];
            4'd6:    lane_car = car_q[3];
            default: lane_car = car_q[0];
        endcase
        unique case (fy_q)
            4'd8:    lane_log = log_q[1];
            4'd9:    lane_log = log_q[2];
            default: lane_log = log_q[0];
        endcase
        // Distance from the log's left end, mod 11; the 4-bit wrap of fx+11 cancels out.
        log_off  = (fx_q >= lane_log) ? (fx_q - lane_log) : (fx_q + 4'd11 - lane_log);
        car_hit  = on_road && (lane_car == fx_q);
        log_miss = on_river && (log_off > 4'd2);
    end

    // Next-state and next-value logic for the game FSM and all playfield registers.
    always_comb begin
        state_n = state_q;
        fx_n    = fx_q;
        fy_n    = fy_q;
        for (int i = 0; i < 4; i++) car_n[i] = car_q[i];
        for (int i = 0; i < 3; i++) log_n[i] = log_q[i];
        lives_n = lives_q;
        vis_n   = vis_q;
        step_n  = step_q;
        dcnt_n  = dcnt_q;
        mx      = fx_q;
        my      = fy_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_n = S_PLAY;
            end
            S_PLAY: begin
                if (fy_q == 4'd10) begin
                    state_n = S_WIN;
                end else if (car_hit || log_miss) begin
                    state_n = S_DEATH;
                    lives_n = lives_q - 2'd1;
                    dcnt_n  = '0;
                    vis_n   = 1'b1;
                end else begin
                    // A blocked higher-priority move still swallows the lower ones.
                    if (btn_up) begin
                        if (fy_q != 4'd10) my = fy_q + 4'd1;
                    end else if (btn_down) begin
                        if (fy_q != 4'd1) my = fy_q - 4'd1;
                    end else if (btn_left) begin
                        if (fx_q != 4'd0) mx = fx_q - 4'd1;
                    end else if (btn_right) begin
                        if (fx_q != 4'd10) mx = fx_q + 4'd1;
                    end
                    fx_n = mx;
                    fy_n = my;
                    if (tick) begin
                        if (step_q == STEP_LAST) begin
                            step_n   = '0;
                            car_n[0] = inc11(car_q[0]);
                            car_n[1] = dec11(car_q[1]);
                            car_n[2] = inc11(car_q[2]);
                            car_n[3] = dec11(car_q[3]);
                            log_n[0] = inc11(log_q[0]);
                            log_n[1] = dec11(log_q[1]);
                            log_n[2] = inc11(log_q[2]);
                            // Ride the log from the already-moved position; riding off the edge kills.
                            if ((my == 4'd7 && mx == 4'd10) || (my == 4'd9 && mx == 4'd10) ||
                                (my == 4'd8 && mx == 4'd0)) begin
                                state_n = S_DEATH;
                                lives_n = lives_q - 2'd1;
                                dcnt_n  = '0;
                                vis_n   = 1'b1;
                            end else if (my == 4'd7 || my == 4'd9) begin
                                fx_n = mx + 4'd1;
                            end else if (my == 4'd8) begin
                                fx_n = mx - 4'd1;
                            end
                        end else begin
                            step_n = step_q + 1'b1;
                        end
                    end
                end
            end
            S_DEATH: begin
                if (tick) begin
                    if (dcnt_q == DEATH_LAST) begin
                        if (lives_q == 2'd0) begin
                            state_n = S_OVER;
                        end else begin
                            state_n = S_PLAY;
                            fx_n    = 4'd5;
                            fy_n    = 4'd1;
                            vis_n   = 1'b1;
                            dcnt_n  = '0;
                        end
                    end else begin
                        dcnt_n = dcnt_inc;
                        vis_n  = ~dcnt_inc[2];
                    end
                end
            end
            S_WIN, S_OVER: begin
                if (start) begin
                    state_n  = S_PLAY;
                    fx_n     = 4'd5;
                    fy_n     = 4'd1;
                    car_n[0] = 4'd0;
                    car_n[1] = 4'd3;
                    car_n[2] = 4'd6;
                    car_n[3] = 4'd9;
                    log_n[0] = 4'd3;
                    log_n[1] = 4'd4;
                    log_n[2] = 4'd3;
                    lives_n  = 2'(LIVES);
                    vis_n    = 1'b1;
                    step_n   = '0;
                    dcnt_n   = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and playfield registers with synchronous reset to the power-on layout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            fx_q     <= 4'd5;
            fy_q     <= 4'd1;
            car_q[0] <= 4'd0;
            car_q[1] <= 4'd3;
            car_q[2] <= 4'd6;
            car_q[3] <= 4'd9;
            log_q[0] <= 4'd3;
            log_q[1] <= 4'd4;
            log_q[2] <= 4'd3;
            lives_q  <= 2'(LIVES);
            vis_q    <= 1'b1;
            step_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q <= state_n;
            fx_q    <= fx_n;
            fy_q    <= fy_n;
            for (int i = 0; i < 4; i++) car_q[i] <= car_n[i];
            for (int i = 0; i < 3; i++) log_q[i] <= log_n[i];
            lives_q <= lives_n;
            vis_q   <= vis_n;
            step_q  <= step_n;
            dcnt_q  <= dcnt_n;
        end
    end

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Self-checking bench for frog_game_ctrl: vector table, corner-case sequences and random play vs a reference model.
// Latency: inputs driven on the falling edge, outputs compared on the following falling edge.
// Backpressure: none; the bench drives pulses freely.
module tb_frog_game_ctrl;

    localparam int ST = 3;
    localparam int NL = 3;
    localparam int DT = 32;

    logic        clk = 1'b0;
    logic        rst_n, start, btn_up, btn_down, btn_left, btn_right, tick;
    logic [3:0]  frog_x, frog_y;
    logic [15:0] car_x;
    logic [11:0] log_x;
    logic [1:0]  lives;
    logic [2:0]  state;
    logic        frog_visible;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers, modulo-11 lane arithmetic.
    int m_st, m_fx, m_fy, m_lives, m_vis, m_stepc, m_dc;
    int m_car [4];
    int m_log [3];

    typedef struct {
        logic       rst_n, start, up, down, left, right, tick;
        logic [3:0] ex, ey;
        logic [2:0] est;
        logic [1:0] elv;
    } vec_t;

    vec_t vecs [11];

    frog_game_ctrl #(.STEP_TICKS(ST), .LIVES(NL), .DEATH_TICKS(DT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .tick(tick), .frog_x(frog_x), .frog_y(frog_y), .car_x(car_x), .log_x(log_x),
        .lives(lives), .state(state), .frog_visible(frog_visible)
    );

    always #5 clk = ~clk;

    task automatic model_init();
        m_fx = 5; m_fy = 1;
        m_car[0] = 0; m_car[1] = 3; m_car[2] = 6; m_car[3] = 9;
        m_log[0] = 3; m_log[1] = 4; m_log[2] = 3;
        m_lives = NL; m_vis = 1; m_stepc = 0; m_dc = 0;
    endtask

    task automatic model_die();
        m_st = 2; m_lives = m_lives - 1; m_dc = 0; m_vis = 1;
    endtask

    task automatic model_update(input logic r, s, u, d, l, rt, t);
        int nx, ny, dir;
        bit hit;
        if (!r) begin
            model_init();
            m_st = 0;
            return;
        end
        case (m_st)
            0: if (s) m_st = 1;
            1: begin
                hit = 1'b0;
                if (m_fy >= 3 && m_fy <= 6) hit = (m_car[m_fy-3] == m_fx);
                if (m_fy >= 7 && m_fy <= 9) hit = (((m_fx - m_log[m_fy-7] + 11) % 11) > 2);
                if (m_fy == 10) m_st = 3;
                else if (hit) model_die();
                else begin
                    nx = m_fx; ny = m_fy;
                    if (u) ny = m_fy + 1;
                    else if (d) ny = m_fy - 1;
                    else if (l) nx = m_fx - 1;
                    else if (rt) nx = m_fx + 1;
                    if (nx >= 0 && nx <= 10 && ny >= 1 && ny <= 10) begin
                        m_fx = nx; m_fy = ny;
                    end
                    if (t) begin
                        m_stepc = m_stepc + 1;
                        if (m_stepc == ST) begin
                            m_stepc = 0;
                            // Odd rows drift right, even rows drift left.
                            for (int i = 0; i < 4; i++) begin
                                dir = ((3 + i) % 2 == 1) ? 1 : -1;
                                m_car[i] = (m_car[i] + dir + 11) % 11;
                            end
                            for (int i = 0; i < 3; i++) begin
                                dir = ((7 + i) % 2 == 1) ? 1 : -1;
                                m_log[i] = (m_log[i] + dir + 11) % 11;
                            end
                            if (m_fy >= 7 && m_fy <= 9) begin
                                dir = (m_fy % 2 == 1) ? 1 : -1;
                                nx = m_fx + dir;
                                if (nx < 0 || nx > 10) model_die();
                                else m_fx = nx;
                            end
                        end
                    end
                end
            end
            2: if (t) begin
                m_dc = m_dc + 1;
                if (m_dc == DT) begin
                    if (m_lives == 0) m_st = 4;
                    else begin
                        m_st = 1; m_fx = 5; m_fy = 1; m_vis = 1; m_dc = 0;
                    end
                end else begin
                    m_vis = ((m_dc / 4) % 2 == 0) ? 1 : 0;
                end
            end
            default: if (s) begin
                model_init();
                m_st = 1;
            end
        endcase
    endtask

    function automatic logic [41:0] model_vec();
        return {m_fx[3:0], m_fy[3:0], m_car[3][3:0], m_car[2][3:0], m_car[1][3:0], m_car[0][3:0],
                m_log[2][3:0], m_log[1][3:0], m_log[0][3:0], m_lives[1:0], m_st[2:0], m_vis[0]};
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, compare at the next fall.
    task automatic apply(input logic r, s, u, d, l, rt, t, input string name);
        rst_n = r; start = s; btn_up = u; btn_down = d; btn_left = l; btn_right = rt; tick = t;
        @(posedge clk);
        model_update(r, s, u, d, l, rt, t);
        @(negedge clk);
        check_eq(name, {frog_x, frog_y, car_x, log_x, lives, state, frog_visible}, model_vec());
    endtask

    task automatic idle(input string n);     apply(1, 0, 0, 0, 0, 0, 0, n); endtask
    task automatic do_reset();               apply(0, 0, 0, 0, 0, 0, 0, "reset"); endtask
    task automatic do_start();               apply(1, 1, 0, 0, 0, 0, 0, "start"); endtask
    task automatic up(input int n);          for (int i = 0; i < n; i++) apply(1, 0, 1, 0, 0, 0, 0, "up"); endtask
    task automatic down(input int n);        for (int i = 0; i < n; i++) apply(1, 0, 0, 1, 0, 0, 0, "down"); endtask
    task automatic ticks(input int n);       for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 1, "tick"); endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; tick = 1'b0;
        model_init();
        m_st = 0;

        // {rst_n,start,up,down,left,right,tick, expected x,y,state,lives}
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  4'd1, 3'd0, 2'd3};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  4'd1, 3'd0, 2'd3};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  4'd1, 3'd1, 2'd3};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5,  4'd1, 3'd1, 2'd3};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5,  4'd2, 3'd1, 2'd3};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6,  4'd2, 3'd1, 2'd3};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7,  4'd2, 3'd1, 2'd3};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8,  4'd2, 3'd1, 2'd3};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9,  4'd2, 3'd1, 2'd3};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 4'd2, 3'd1, 2'd3};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 4'd2, 3'd1, 2'd3};

        @(negedge clk);

        // Reset, clamp and move priority.
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i].rst_n, vecs[i].start, vecs[i].up, vecs[i].down, vecs[i].left,
                  vecs[i].right, vecs[i].tick, $sformatf("vec%0d_model", i));
            check_eq($sformatf("vec%0d_pos", i), {frog_x, frog_y}, {vecs[i].ex, vecs[i].ey});
            check_eq($sformatf("vec%0d_state", i), state, vecs[i].est);
            check_eq($sformatf("vec%0d_lives", i), lives, vecs[i].elv);
            if (i == 1) begin
                check_eq("reset_car_x", car_x, 16'h9630);
                check_eq("reset_log_x", log_x, 12'h343);
                check_eq("reset_visible", frog_visible, 1'b1);
            end
        end

        // Car death, blinking and respawn.
        do_reset(); do_start();
        apply(1, 0, 0, 0, 1, 0, 0, "left");
        apply(1, 0, 0, 0, 1, 0, 0, "left");
        up(3);
        check_eq("car_pos", {frog_x, frog_y}, {4'd3, 4'd4});
        check_eq("car_pre_state", state, 3'd1);
        idle("car_hit");
        check_eq("car_state", state, 3'd2);
        check_eq("car_lives", lives, 2'd2);
        for (int k = 1; k <= DT; k++) begin
            ticks(1);
            if (k < DT) check_eq($sformatf("blink%0d", k), frog_visible, ((k / 4) % 2 == 0) ? 1'b1 : 1'b0);
        end
        check_eq("respawn_pos", {frog_x, frog_y}, {4'd5, 4'd1});
        check_eq("respawn_state", state, 3'd1);
        check_eq("respawn_lives", lives, 2'd2);
        check_eq("death_frozen_cars", car_x, 16'h9630);

        // Obstacle step, log ride and full wrap back to the initial lanes.
        do_reset(); do_start();
        up(6);
        idle("on_log");
        check_eq("on_log_state", state, 3'd1);
        ticks(ST);
        check_eq("ride_log7", log_x[3:0], 4'd4);
        check_eq("ride_fx", frog_x, 4'd6);
        check_eq("step_lane3", car_x[3:0], 4'd1);
        check_eq("step_lane4", car_x[7:4], 4'd2);
        down(6);
        ticks(10 * ST);
        check_eq("wrap_cars", car_x, 16'h9630);
        check_eq("wrap_logs", log_x, 12'h343);
        check_eq("wrap_state", state, 3'd1);

        // River deaths to game over, then restart.
        do_reset(); do_start();
        for (int d = 0; d < 3; d++) begin
            up(6);
            apply(1, 0, 0, 0, 0, 1, 0, "off_log");
            idle("river_hit");
            check_eq($sformatf("river%0d_state", d), state, 3'd2);
            check_eq($sformatf("river%0d_lives", d), 32'(2 - d), 32'(lives));
            ticks(DT);
        end
        check_eq("over_state", state, 3'd4);
        check_eq("over_lives", lives, 2'd0);
        up(1);
        check_eq("over_hold", {frog_x, frog_y}, {4'd6, 4'd7});
        do_start();
        check_eq("restart_state", state, 3'd1);
        check_eq("restart_lives", lives, 2'd3);
        check_eq("restart_pos", {frog_x, frog_y}, {4'd5, 4'd1});
        check_eq("restart_lanes", {car_x, log_x}, {16'h9630, 12'h343});

        // Win, buttons ignored, reset mid-win.
        do_reset(); do_start();
        do_start();
        up(9);
        check_eq("goal_pos", {frog_x, frog_y}, {4'd5, 4'd10});
        idle("win");
        check_eq("win_state", state, 3'd3);
        down(1);
        apply(1, 0, 0, 0, 1, 0, 1, "win_left");
        check_eq("win_hold", {frog_x, frog_y, state}, {4'd5, 4'd10, 3'd3});
        do_reset();
        check_eq("win_reset", {state, frog_x, frog_y, lives}, {3'd0, 4'd5, 4'd1, 2'd3});

        // Random play against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            apply($urandom_range(0, 299) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
